sdram_responder: RTL

Synthesizable single-chip SDR SDRAM device responder for the 16-bit SDRAM pin interface driven by the team's SDRAM controller.
- Decodes controller commands (ACTIVE, READ, WRITE, PRECHARGE, AUTO_REFRESH, LOAD_MODE, BURST_TERMINATE).
- Tracks per-bank open rows and the mode register.
- Returns read bursts at the programmed CAS latency from an internal RAM.
- Flags protocol violations.
- Used in simulation benches and in FPGA loopback builds without a physical SDRAM.

---
 rtl/sdram_pkg.sv | 76 +++++++
 rtl/sdram_resp_mem.sv | 24 ++
 rtl/sdram_responder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM device responder:
// command encodings, mode fields, error bit indices and burst helpers.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  localparam int MR_BL_LSB = 0;
  localparam int MR_AT     = 3;
  localparam int MR_CL_LSB = 4;
  localparam int MR_WB     = 9;
  localparam int A_AP      = 10;

  localparam int E_NOMODE   = 0;
  localparam int E_ACT_OPEN = 1;
  localparam int E_CLOSED   = 2;
  localparam int E_REF_OPEN = 3;
  localparam int E_MODE     = 4;

  typedef struct packed {
    logic [1:0] bl;
    logic       il;
    logic       cl3;
    logic       wsingle;
    logic       bad;
  } mode_t;

  function automatic mode_t mode_decode(
    input logic [12:0] a
  );
    mode_t m;
    logic [2:0] cl;
    cl        = a[MR_CL_LSB +: 3];
    m.il      = a[MR_AT];
    m.wsingle = a[MR_WB];
    m.bad     = a[MR_BL_LSB + 2]
              | !((cl == 3'd2) || (cl == 3'd3));
    m.bl      = m.bad ? 2'd0 : a[MR_BL_LSB +: 2];
    m.cl3     = !m.bad && (cl == 3'd3);
    return m;
  endfunction

  // Column of beat i; only the low log2(BL) bits move.
  function automatic logic [8:0] burst_col(
    input logic [8:0] col,
    input logic [2:0] i,
    input logic [1:0] bl,
    input logic       il
  );
    logic [8:0] msk;
    logic [8:0] ii;
    msk = (9'd1 << bl) - 9'd1;
    ii  = {6'd0, i};
    if (il)
      return col ^ (ii & msk);
    return (col & ~msk) | ((col + ii) & msk);
  endfunction

  function automatic logic burst_last(
    input logic [2:0] i,
    input logic [1:0] bl
  );
    logic [3:0] n;
    n = (4'd1 << bl) - 4'd1;
    return {1'b0, i} == n;
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port synchronous RAM, 16-bit words, two byte enables.
// Read-first: rdata shows the old word on a write cycle.
module sdram_resp_mem #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we && be[0])
      mem[addr][7:0] <= wdata[7:0];
    if (we && be[1])
      mem[addr][15:8] <= wdata[15:8];
  end

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device responder: command decode, bank/mode tracking,
// CAS-latency read bursts and write bursts into an internal RAM.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_W = 4,
  parameter int COL_W = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SDRAM_CKE,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic [1:0]  SDRAM_BA,
  input  logic [12:0] SDRAM_A,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] SDRAM_DQ_IN,
  output logic [15:0] SDRAM_DQ_OUT,
  output logic        SDRAM_DQ_OE,
  output logic [15:0] refresh_cnt,
  output logic [4:0]  err
);

  localparam int AW = 2 + ROW_W + COL_W;

  cmd_e cmd;
  logic is_act, is_rd, is_wr, is_pre;
  logic is_ref, is_mrs, is_bst, kill;

  assign cmd = (!SDRAM_nCS && SDRAM_CKE)
             ? cmd_e'({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE})
             : CMD_NOP;

  assign is_act = (cmd == CMD_ACT);
  assign is_rd  = (cmd == CMD_RD);
  assign is_wr  = (cmd == CMD_WR);
  assign is_pre = (cmd == CMD_PRE);
  assign is_ref = (cmd == CMD_REF);
  assign is_mrs = (cmd == CMD_MRS);
  assign is_bst = (cmd == CMD_BST);
  assign kill   = is_rd | is_wr | is_bst;

  logic [3:0]       bank_open;
  logic [ROW_W-1:0] bank_row [4];
  logic             mode_valid;
  mode_t            mode;
  mode_t            mode_nxt;
  logic [ROW_W-1:0] acc_row;

  assign acc_row  = bank_row[SDRAM_BA];
  assign mode_nxt = mode_decode(SDRAM_A);

  logic             rd_busy;
  logic [2:0]       rd_i;
  logic [1:0]       rd_ba;
  logic [ROW_W-1:0] rd_row;
  logic [8:0]       rd_col;
  logic [1:0]       rd_bl;
  logic             rd_il;

  logic             wr_busy;
  logic [2:0]       wr_i;
  logic [1:0]       wr_ba;
  logic [ROW_W-1:0] wr_row;
  logic [8:0]       wr_col;
  logic [1:0]       wr_bl;
  logic             wr_il;

  logic             mem_we;
  logic [1:0]       mem_be;
  logic [AW-1:0]    mem_addr;
  logic [15:0]      mem_q;
  logic             rd_iss;
  logic             mem_vld;

  // Read and write bursts never overlap, so one RAM port suffices.
  always_comb begin
    mem_we   = 1'b0;
    mem_be   = 2'b00;
    mem_addr = '0;
    rd_iss   = 1'b0;
    unique case (1'b1)
      is_wr: begin
        mem_we   = 1'b1;
        mem_be   = {~SDRAM_DQMH, ~SDRAM_DQML};
        mem_addr = {SDRAM_BA, acc_row, SDRAM_A[8:0]};
      end
      (wr_busy && !kill): begin
        mem_we   = 1'b1;
        mem_be   = {~SDRAM_DQMH, ~SDRAM_DQML};
        mem_addr = {wr_ba, wr_row,
                    burst_col(wr_col, wr_i, wr_bl, wr_il)};
      end
      (is_rd && !mode.cl3): begin
        rd_iss   = 1'b1;
        mem_addr = {SDRAM_BA, acc_row, SDRAM_A[8:0]};
      end
      (rd_busy && !kill): begin
        rd_iss   = 1'b1;
        mem_addr = {rd_ba, rd_row,
                    burst_col(rd_col, rd_i, rd_bl, rd_il)};
      end
      default: ;
    endcase
  end

  sdram_resp_mem #(
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (SDRAM_DQ_IN),
    .rdata (mem_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_vld      <= 1'b0;
      SDRAM_DQ_OE  <= 1'b0;
      SDRAM_DQ_OUT <= '0;
    end else begin
      mem_vld     <= rd_iss;
      SDRAM_DQ_OE <= mem_vld && !kill;
      if (mem_vld && !kill)
        SDRAM_DQ_OUT <= mem_q;
    end
  end

  // CL2 issues beat 0 at the command edge; CL3 one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_busy <= 1'b0;
      rd_i    <= '0;
      rd_ba   <= '0;
      rd_row  <= '0;
      rd_col  <= '0;
      rd_bl   <= '0;
      rd_il   <= 1'b0;
    end else if (is_rd) begin
      rd_ba  <= SDRAM_BA;
      rd_row <= acc_row;
      rd_col <= SDRAM_A[8:0];
      rd_bl  <= mode.bl;
      rd_il  <= mode.il;
      if (mode.cl3) begin
        rd_busy <= 1'b1;
        rd_i    <= 3'd0;
      end else begin
        rd_busy <= (mode.bl != 2'd0);
        rd_i    <= 3'd1;
      end
    end else if (kill) begin
      rd_busy <= 1'b0;
    end else if (rd_busy) begin
      rd_i <= rd_i + 3'd1;
      if (burst_last(rd_i, rd_bl))
        rd_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_busy <= 1'b0;
      wr_i    <= '0;
      wr_ba   <= '0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_bl   <= '0;
      wr_il   <= 1'b0;
    end else if (is_wr) begin
      wr_busy <= !mode.wsingle && (mode.bl != 2'd0);
      wr_i    <= 3'd1;
      wr_ba   <= SDRAM_BA;
      wr_row  <= acc_row;
      wr_col  <= SDRAM_A[8:0];
      wr_bl   <= mode.bl;
      wr_il   <= mode.il;
    end else if (kill) begin
      wr_busy <= 1'b0;
    end else if (wr_busy) begin
      wr_i <= wr_i + 3'd1;
      if (burst_last(wr_i, wr_bl))
        wr_busy <= 1'b0;
    end
  end

  // Row registers survive a close: closed-bank accesses reuse them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_open   <= '0;
      for (int b = 0; b < 4; b++)
        bank_row[b] <= '0;
      mode_valid  <= 1'b0;
      mode        <= '0;
      refresh_cnt <= '0;
      err         <= '0;
    end else begin
      if ((is_act || is_rd || is_wr || is_bst) && !mode_valid)
        err[E_NOMODE] <= 1'b1;
      unique case (1'b1)
        is_act: begin
          if (bank_open[SDRAM_BA])
            err[E_ACT_OPEN] <= 1'b1;
          bank_open[SDRAM_BA] <= 1'b1;
          bank_row[SDRAM_BA]  <= SDRAM_A[ROW_W-1:0];
        end
        (is_rd || is_wr): begin
          if (!bank_open[SDRAM_BA])
            err[E_CLOSED] <= 1'b1;
          if (SDRAM_A[A_AP])
            bank_open[SDRAM_BA] <= 1'b0;
        end
        is_pre: begin
          if (SDRAM_A[A_AP])
            bank_open <= '0;
          else
            bank_open[SDRAM_BA] <= 1'b0;
        end
        is_ref: begin
          refresh_cnt <= refresh_cnt + 16'd1;
          if (|bank_open)
            err[E_REF_OPEN] <= 1'b1;
        end
        is_mrs: begin
          mode       <= mode_nxt;
          mode_valid <= 1'b1;
          if (mode_nxt.bad)
            err[E_MODE] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
